// File: rtl/pll_lock_supervisor.sv
// Reset and lock supervisor for the crystal-to-system-clock rPLL.
// Pulses the PLL reset, waits for a stable synchronized lock, then releases the system reset.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 27,
    parameter int LOCK_TIMEOUT   = 270000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int HOLD_CYCLES    = 64,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lock,
    output logic             pll_reset,
    output logic             sys_rst,
    output logic             ready,
    output logic [CNT_W-1:0] loss_count,
    output logic [CNT_W-1:0] timeout_count
);

    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC + 1) : 1;

    localparam logic [TIMER_W-1:0] PLL_RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST    = TIMER_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;

    typedef enum logic [2:0] {
        ST_PLL_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                 pll_reset_q, pll_reset_d;
    logic                 sys_rst_q, sys_rst_d;
    logic                 ready_q, ready_d;
    logic [CNT_W-1:0]     loss_count_q, loss_count_d;
    logic [CNT_W-1:0]     timeout_count_q, timeout_count_d;
    logic                 lock_s;
    logic                 loss_inc;
    logic                 timeout_inc;

    // Only the last synchronizer stage is ever looked at by the FSM.
    assign lock_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d          = {sync_q[SYNC_STAGES-2:0], lock};
        state_d         = state_q;
        loss_inc        = 1'b0;
        timeout_inc     = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (timer_q == PLL_RST_LAST) state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d     = ST_PLL_RST;
                    timeout_inc = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s)                    state_d = ST_WAIT_LOCK;
                else if (timer_q == STABLE_LAST) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (!lock_s)                  state_d = ST_WAIT_LOCK;
                else if (timer_q == HOLD_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_WAIT_LOCK;
                    loss_inc = 1'b1;
                end
            end
            default: state_d = ST_PLL_RST;
        endcase

        // Timer restarts on every transition; it idles in RUN where nothing is timed.
        if (state_d != state_q)   timer_d = '0;
        else if (state_q == ST_RUN) timer_d = timer_q;
        else                      timer_d = timer_q + TIMER_W'(1);

        loss_count_d    = (loss_inc && loss_count_q != CNT_MAX) ?
                          loss_count_q + CNT_W'(1) : loss_count_q;
        timeout_count_d = (timeout_inc && timeout_count_q != CNT_MAX) ?
                          timeout_count_q + CNT_W'(1) : timeout_count_q;

        // Decoding from the next state keeps outputs aligned with the state register.
        pll_reset_d = (state_d == ST_PLL_RST);
        sys_rst_d   = (state_d != ST_RUN);
        ready_d     = (state_d == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_PLL_RST;
            timer_q         <= '0;
            sync_q          <= '0;
            pll_reset_q     <= 1'b1;
            sys_rst_q       <= 1'b1;
            ready_q         <= 1'b0;
            loss_count_q    <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            sync_q          <= sync_d;
            pll_reset_q     <= pll_reset_d;
            sys_rst_q       <= sys_rst_d;
            ready_q         <= ready_d;
            loss_count_q    <= loss_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign pll_reset     = pll_reset_q;
    assign sys_rst       = sys_rst_q;
    assign ready         = ready_q;
    assign loss_count    = loss_count_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor: bring-up table plus hand-written corner sequences.
module tb_pll_lock_supervisor;

    logic       clk;
    logic       rst;
    logic       lock;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic [1:0] loss_count;
    logic [1:0] timeout_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pll_lock_supervisor #(
        .SYNC_STAGES   (2),
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (100),
        .STABLE_CYCLES (16),
        .HOLD_CYCLES   (8),
        .CNT_W         (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .lock         (lock),
        .pll_reset    (pll_reset),
        .sys_rst      (sys_rst),
        .ready        (ready),
        .loss_count   (loss_count),
        .timeout_count(timeout_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic rst;
        logic lock;
        logic exp_pll;
        logic exp_sys;
        logic exp_rdy;
    } vec_t;

    vec_t vecs[46];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Lock was raised just before the next edge (edge 0); ready must rise exactly at edge n.
    task automatic expect_ready(input string name, input int n);
        repeat (n) tick();
        check({name, " ready before"}, ready, 0);
        check({name, " sys_rst before"}, sys_rst, 1);
        tick();
        check({name, " ready at edge"}, ready, 1);
        check({name, " sys_rst at edge"}, sys_rst, 0);
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        int r;
        int k_sat;

        // Clean bring-up: reset edges 0..2, WAIT_LOCK from edge 6, lock before edge 16, ready at 42.
        for (int c = 0; c < 46; c++) begin
            vecs[c].rst     = (c < 3);
            vecs[c].lock    = (c >= 16);
            vecs[c].exp_pll = (c <= 5);
            vecs[c].exp_rdy = (c >= 42);
            vecs[c].exp_sys = (c < 42);
        end

        rst  = 1'b1;
        lock = 1'b0;
        for (int c = 0; c < 46; c++) begin
            rst  = vecs[c].rst;
            lock = vecs[c].lock;
            tick();
            check($sformatf("bringup[%0d] pll_reset", c), pll_reset, vecs[c].exp_pll);
            check($sformatf("bringup[%0d] sys_rst", c), sys_rst, vecs[c].exp_sys);
            check($sformatf("bringup[%0d] ready", c), ready, vecs[c].exp_rdy);
        end
        check("bringup loss_count", loss_count, 0);
        check("bringup timeout_count", timeout_count, 0);

        // Run loss: drop lock, ready falls at edge 2.
        lock = 1'b0;
        tick();
        tick();
        check("loss1 ready at e1", ready, 1);
        check("loss1 count at e1", loss_count, 0);
        tick();
        check("loss1 ready at e2", ready, 0);
        check("loss1 sys_rst at e2", sys_rst, 1);
        check("loss1 count at e2", loss_count, 1);
        lock = 1'b1;
        expect_ready("relock1", 26);

        // Second loss, then drop lock 3 cycles into HOLD.
        lock = 1'b0;
        repeat (3) tick();
        check("loss2 count", loss_count, 2);
        check("loss2 ready", ready, 0);
        lock = 1'b1;
        repeat (19) tick();
        lock = 1'b0;
        repeat (3) tick();
        check("holddrop sys_rst", sys_rst, 1);
        check("holddrop ready", ready, 0);
        check("holddrop pll_reset", pll_reset, 0);
        check("holddrop loss_count", loss_count, 2);
        lock = 1'b1;
        expect_ready("holddrop relock", 26);
        check("holddrop loss_count after", loss_count, 2);

        // Mid-run reset with loss_count = 2.
        rst  = 1'b1;
        lock = 1'b0;
        tick();
        check("midreset pll_reset", pll_reset, 1);
        check("midreset sys_rst", sys_rst, 1);
        check("midreset ready", ready, 0);
        check("midreset loss_count", loss_count, 0);
        check("midreset timeout_count", timeout_count, 0);
        rst = 1'b0;

        // Unstable lock: high 10, low 1, high; WAIT_LOCK entered 4 edges after reset.
        repeat (3) tick();
        check("unstable pll_reset e3", pll_reset, 1);
        tick();
        check("unstable pll_reset e4", pll_reset, 0);
        repeat (2) tick();
        lock = 1'b1;
        repeat (10) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        expect_ready("unstable", 26);
        check("unstable loss_count", loss_count, 0);

        // Timeout: lock held low; pll_reset re-pulses every 104 edges, count saturates at 3.
        rst  = 1'b1;
        lock = 1'b0;
        tick();
        rst = 1'b0;
        r   = cyc;
        check("timeout start count", timeout_count, 0);
        for (int k = 1; k <= 4; k++) begin
            k_sat = (k > 3) ? 3 : k;
            tick_to(r + 104 * k - 1);
            check($sformatf("timeout%0d pll before", k), pll_reset, 0);
            check($sformatf("timeout%0d count before", k), timeout_count, k - 1 > 3 ? 3 : k - 1);
            tick_to(r + 104 * k);
            check($sformatf("timeout%0d pll at", k), pll_reset, 1);
            check($sformatf("timeout%0d count at", k), timeout_count, k_sat);
            check($sformatf("timeout%0d sys_rst", k), sys_rst, 1);
            tick_to(r + 104 * k + 3);
            check($sformatf("timeout%0d pll held", k), pll_reset, 1);
            tick_to(r + 104 * k + 4);
            check($sformatf("timeout%0d pll fall", k), pll_reset, 0);
        end
        check("timeout loss_count", loss_count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
